counter_163p: RTL and testbench
===============================

Name: counter_163p

Overview:
- Pin-level emulator model of a 74xx163 4-bit synchronous binary counter with synchronous clear, parallel load, count enables and ripple-carry output.
- Its outputs feed pin-level logic models such as the 74xx04 inverter, e.g. an inverted step-counter line into control decode.
- The chip's CP pin is a sampled signal, not a Verilog clock. The model runs on the emulator system clock and acts on detected CP rising edges.
- Cascades through rco/ent to build 8-bit program or step counters.

Parameters:
- RESET_VALUE, 4'h0: value loaded into {qd,qc,qb,qa} on system reset.

Ports:
- clk  input  1  emulator system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high system reset
- cp  input  1  chip clock pin, sampled on clk
- clr_n  input  1  synchronous clear pin, active low
- load_n  input  1  synchronous parallel-load pin, active low
- enp  input  1  count enable P
- ent  input  1  count enable T; also gates rco
- a  input  1  load data bit 0
- b  input  1  load data bit 1
- c  input  1  load data bit 2
- d  input  1  load data bit 3
- qa  output  1  count bit 0 (LSB)
- qb  output  1  count bit 1
- qc  output  1  count bit 2
- qd  output  1  count bit 3 (MSB)
- rco  output  1  ripple carry out

Behaviour:
- State:
  - q[3:0], drives {qd,qc,qb,qa}.
  - cp_prev, the cp value sampled at the previous clk edge.
- Reset:
  - When reset=1 at a clk edge: q <= RESET_VALUE and cp_prev <= 1.
  - Reset has priority over everything, including a CP edge in the same cycle.
  - Setting cp_prev to 1 means cp held high through reset release causes no count.
- Edge detect:
  - At every non-reset clk edge, cp_prev <= cp.
  - An active edge is cp_prev=0 and cp=1 at that clk edge.
  - A pulse that appears on cp between two clk edges and disappears before the next is not seen.
- Latency:
  - q updates at the same clk edge that detects the edge and is visible right after it.
  - The observed latency from cp going high is at most 1 clk.
- On an active edge, in priority order:
  1. clr_n=0: q <= 0, regardless of load_n/enp/ent.
  2. else load_n=0: q <= {d,c,b,a}, regardless of enp/ent.
  3. else enp=1 and ent=1: q <= q+1, modulo 16, so F wraps to 0.
  4. else q holds.
- With no active edge, q holds whatever the pins do.
- cp falling edges and a constant level do nothing.
- rco is combinational: rco = ent & (q == 4'hF). It does not depend on enp or cp.
- Unknown pins, without the optional feature:
  - X/Z on clr_n or load_n is treated as inactive (1).
  - X/Z on enp or ent is treated as 0.
  - X/Z on cp is treated as 0 for edge detection.
- Outputs never take X except under the optional feature.

Optional Feature:
- Macro: COUNTER_163P_XPROP_EN.
- When defined:
  - At an active edge, if any pin that selects the taken branch is X/Z, q <= 4'bxxxx.
  - Selecting pins are clr_n; load_n when clr_n=1; enp/ent when clr_n=load_n=1.
  - Loading X/Z data bits stores them as X in the matching q bit.
  - rco propagates X per Verilog & semantics.
  - cp=X never counts as an edge.
- When not defined: the X/Z handling in Behaviour applies and q is always 0/1.

Test Plan:
- Reset and hold:
  - Stimulus: reset=1 for 2 clk with cp toggling, then release with cp=1.
  - Response: q=RESET_VALUE=0 and rco=0; no count on the first clk after release.
- Count and wrap:
  - Stimulus: enp=ent=1, clr_n=load_n=1; 17 cp rising edges, each cp level held 2 clk.
  - Response: q steps 1..F then 0; rco=1 only while q=F; exactly one increment per cp rise, none on falls.
- Load priority:
  - Stimulus: q=3, load_n=0, enp=ent=1, {d,c,b,a}=4'hA, one cp rise.
  - Response: q=A, not 4.
  - Then clr_n=0 and load_n=0 together, cp rise: q=0.
- Enable gating:
  - Stimulus: q=F; with enp=0, ent=1: cp rise leaves q=F and rco=1.
  - Then ent=0: rco=0 immediately and a cp rise leaves q=F.
- Reset mid-operation:
  - Stimulus: q=7 counting; reset=1 at the same clk edge that sees a cp rise.
  - Response: q=0 (reset wins); cp held high after release gives no count.
- X handling:
  - Stimulus: load_n=X, clr_n=1, enp=ent=1, cp rise from q=2.
  - Response without the macro: q=3 (load_n treated as inactive).
  - Response with COUNTER_163P_XPROP_EN: q=4'bxxxx.

Source files
------------

// File: rtl/counter_163p.sv
// 74xx163 4-bit synchronous counter model running on the emulator clock; CP is a sampled pin.
// Optional X propagation on pins and state is enabled by defining COUNTER_163P_XPROP_EN.
module counter_163p #(
    parameter logic [3:0] RESET_VALUE = 4'h0
) (
    input  logic clk,
    input  logic reset,
    input  logic cp,
    input  logic clr_n,
    input  logic load_n,
    input  logic enp,
    input  logic ent,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd,
    output logic rco
);

    logic [3:0] q_q, q_d;
    logic       cp_prev_q, cp_prev_d;
    logic       cp_edge;

`ifdef COUNTER_163P_XPROP_EN
    // cp=X never forms an edge, and an X held in cp_prev_q blocks the next one too.
    assign cp_prev_d = cp;
    assign cp_edge   = (cp_prev_q === 1'b0) && (cp === 1'b1);

    always_comb begin
        q_d = q_q;
        if (cp_edge) begin
            if ($isunknown(clr_n)) begin
                q_d = 4'bxxxx;
            end else if (!clr_n) begin
                q_d = 4'h0;
            end else if ($isunknown(load_n)) begin
                q_d = 4'bxxxx;
            end else if (!load_n) begin
                q_d = {d, c, b, a};
            end else if ($isunknown(enp) || $isunknown(ent)) begin
                q_d = 4'bxxxx;
            end else if (enp && ent) begin
                q_d = q_q + 4'd1;
            end
        end
    end

    assign rco = ent & (q_q == 4'hF);
`else
    // Unknown pins collapse to their inactive level so state and outputs stay 0/1.
    logic cp_s, clr_act, load_act, enp_s, ent_s;
    logic [3:0] data_s;

    assign cp_s     = (cp === 1'b1);
    assign clr_act  = (clr_n === 1'b0);
    assign load_act = (load_n === 1'b0);
    assign enp_s    = (enp === 1'b1);
    assign ent_s    = (ent === 1'b1);
    assign data_s   = {d === 1'b1, c === 1'b1, b === 1'b1, a === 1'b1};

    assign cp_prev_d = cp_s;
    assign cp_edge   = !cp_prev_q && cp_s;

    always_comb begin
        q_d = q_q;
        if (cp_edge) begin
            if (clr_act) begin
                q_d = 4'h0;
            end else if (load_act) begin
                q_d = data_s;
            end else if (enp_s && ent_s) begin
                q_d = q_q + 4'd1;
            end
        end
    end

    assign rco = ent_s & (q_q == 4'hF);
`endif

    // cp_prev_q resets high so cp held high across reset release is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q       <= RESET_VALUE;
            cp_prev_q <= 1'b1;
        end else begin
            q_q       <= q_d;
            cp_prev_q <= cp_prev_d;
        end
    end

    assign {qd, qc, qb, qa} = q_q;

endmodule

// File: tb/tb_counter_163p.sv
// Directed bench for counter_163p: a spec-level model is checked every cycle, plus literal checkpoints.
module tb_counter_163p;

    logic clk = 1'b0;
    logic reset, cp, clr_n, load_n, enp, ent, a, b, c, d;
    logic qa, qb, qc, qd, rco;
    logic [3:0] qout;

    int n_cmp = 0;
    int n_bad = 0;

    int   mq    = 0;
    logic mprev = 1'b1;
    bit   mx    = 1'b0;

    counter_163p #(.RESET_VALUE(4'h0)) dut (
        .clk(clk), .reset(reset), .cp(cp), .clr_n(clr_n), .load_n(load_n),
        .enp(enp), .ent(ent), .a(a), .b(b), .c(c), .d(d),
        .qa(qa), .qb(qb), .qc(qc), .qd(qd), .rco(rco)
    );

    assign qout = {qd, qc, qb, qa};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a counter value advanced by the pin rules whenever cp is seen rising.
    always @(posedge clk) begin
        if (reset) begin
            mq    = 0;
            mprev = 1'b1;
            mx    = 1'b0;
        end else begin
            if (mprev == 1'b0 && cp === 1'b1) begin
`ifdef COUNTER_163P_XPROP_EN
                if ($isunknown(clr_n) || (clr_n === 1'b1 && $isunknown(load_n)) ||
                    (clr_n === 1'b1 && load_n === 1'b1 && $isunknown({enp, ent})))
                    mx = 1'b1;
`endif
                if (clr_n === 1'b0) mq = 0;
                else if (load_n === 1'b0) mq = {d === 1'b1, c === 1'b1, b === 1'b1, a === 1'b1};
                else if (enp === 1'b1 && ent === 1'b1) mq = (mq + 1) % 16;
            end
            mprev = (cp === 1'b1);
        end
    end

    always @(negedge clk) begin
        if (!mx) begin
            check("model_q", qout, mq[3:0]);
            check("model_rco", {3'b0, rco}, {3'b0, (ent === 1'b1) && (mq == 15)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cp_rise();
        cp = 1'b0;
        cyc(2);
        cp = 1'b1;
        cyc(2);
    endtask

    task automatic load(input logic [3:0] v);
        load_n = 1'b0;
        {d, c, b, a} = v;
        cp_rise();
        load_n = 1'b1;
    endtask

    initial begin
        reset = 1'b1; cp = 1'b0; clr_n = 1'b1; load_n = 1'b1;
        enp = 1'b1; ent = 1'b1; {d, c, b, a} = 4'h0;

        // Reset with cp toggling, release with cp high: no count.
        cyc(1); cp = 1'b1; cyc(1);
        reset = 1'b0;
        cyc(2);
        check("reset_q", qout, 4'h0);
        check("reset_rco", {3'b0, rco}, 4'h0);

        // Count 17 rises through the wrap.
        for (int i = 1; i <= 17; i++) begin
            cp_rise();
            check("count_q", qout, 4'(i % 16));
            check("count_rco", {3'b0, rco}, {3'b0, i == 15});
        end

        // Load beats count; clear beats load.
        load(4'h3);
        check("load3", qout, 4'h3);
        load_n = 1'b0; {d, c, b, a} = 4'hA;
        cp_rise();
        check("load_over_count", qout, 4'hA);
        clr_n = 1'b0;
        cp_rise();
        check("clr_over_load", qout, 4'h0);
        clr_n = 1'b1; load_n = 1'b1;

        // Enable gating and combinational rco.
        load(4'hF);
        enp = 1'b0; ent = 1'b1;
        cp_rise();
        check("enp0_hold", qout, 4'hF);
        check("enp0_rco", {3'b0, rco}, 4'h1);
        ent = 1'b0;
        #1;
        check("ent0_rco", {3'b0, rco}, 4'h0);
        cp_rise();
        check("ent0_hold", qout, 4'hF);

        // Reset coincident with a cp rise wins; cp high after release does not count.
        load(4'h7);
        enp = 1'b1; ent = 1'b1;
        cp = 1'b0; cyc(2);
        cp = 1'b1; reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check("reset_wins", qout, 4'h0);

        // Unknown load_n; data equals q+1 so a 2-state simulator agrees either way.
        load(4'h2);
        {d, c, b, a} = 4'h3;
        load_n = 1'bx;
        cp_rise();
`ifdef COUNTER_163P_XPROP_EN
        check("x_load_n", qout, 4'bxxxx);
`else
        check("x_load_n", qout, 4'h3);
`endif
        load_n = 1'b1;
        cyc(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
